// File: rtl/rf_sb_multiport.sv
// -----------------------------------------------------------------------------
// rf_sb_multiport
//
// Multi-port integer register file with an integrated write scoreboard.
// Each architectural register holds data, a busy bit and the tag of the
// instruction that will produce it. Issue ports mark destinations busy and
// record the producer tag. Writeback ports clear the busy bit only when their
// tag matches, so a stale producer (one whose destination was retagged by a
// later issue) is silently dropped.
//
// Optional feature macro: RF_SB_BYPASS_EN
//   defined   : same-cycle write-to-read forwarding on rdata/dbg_data, and
//               rbusy is masked by this cycle's accepted writebacks.
//   undefined : reads return array contents only, rbusy is the raw busy bit.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   raddr      NUM_RD packed read addresses
//   rdata      NUM_RD packed read data
//   rbusy      per read port: operand still pending after this cycle
//   dbg_addr   debug read address
//   dbg_data   debug read data (bypassed like rdata)
//   iss_valid  per issue port: mark iss_addr busy with iss_tag
//   iss_addr   NUM_WR packed issue destination addresses
//   iss_tag    NUM_WR packed producer tags
//   we         per writeback port enable
//   waddr      NUM_WR packed writeback addresses
//   wdata      NUM_WR packed writeback data
//   wtag       NUM_WR packed writeback tags
//   busy_cnt   registered number of busy registers
// -----------------------------------------------------------------------------
module rf_sb_multiport #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_RD     = 4,
   parameter int NUM_WR     = 2,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr,
   output logic [NUM_RD*DATA_WIDTH-1:0]   rdata,
   output logic [NUM_RD-1:0]              rbusy,
   input  logic [ADDR_WIDTH-1:0]          dbg_addr,
   output logic [DATA_WIDTH-1:0]          dbg_data,
   input  logic [NUM_WR-1:0]              iss_valid,
   input  logic [NUM_WR*ADDR_WIDTH-1:0]   iss_addr,
   input  logic [NUM_WR*TAG_WIDTH-1:0]    iss_tag,
   input  logic [NUM_WR-1:0]              we,
   input  logic [NUM_WR*ADDR_WIDTH-1:0]   waddr,
   input  logic [NUM_WR*DATA_WIDTH-1:0]   wdata,
   input  logic [NUM_WR*TAG_WIDTH-1:0]    wtag,
   output logic [ADDR_WIDTH:0]            busy_cnt
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CNT_W = ADDR_WIDTH + 1;

   // Architectural state
   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic [DATA_WIDTH-1:0] regs_d [DEPTH];
   logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
   logic [TAG_WIDTH-1:0]  tag_d  [DEPTH];
   logic [DEPTH-1:0]      busy_q;
   logic [DEPTH-1:0]      busy_d;
   logic [CNT_W-1:0]      busy_cnt_q;
   logic [CNT_W-1:0]      busy_cnt_d;

   // Unpacked views of the packed write/issue buses
   logic [ADDR_WIDTH-1:0] wa [NUM_WR];
   logic [DATA_WIDTH-1:0] wd [NUM_WR];
   logic [TAG_WIDTH-1:0]  wt [NUM_WR];
   logic [ADDR_WIDTH-1:0] ia [NUM_WR];
   logic [TAG_WIDTH-1:0]  it [NUM_WR];

   logic [NUM_WR-1:0]     wr_win;   // enabled, non-zero, not overridden by a higher port
   logic [NUM_WR-1:0]     wr_acc;   // winner that also passes the tag check

   genvar gi;
   generate
      for (gi = 0; gi < NUM_WR; gi++) begin : g_unpack
         assign wa[gi] = waddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign wd[gi] = wdata[gi*DATA_WIDTH +: DATA_WIDTH];
         assign wt[gi] = wtag[gi*TAG_WIDTH +: TAG_WIDTH];
         assign ia[gi] = iss_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign it[gi] = iss_tag[gi*TAG_WIDTH +: TAG_WIDTH];
      end
   endgenerate

   // Writeback acceptance. Reset gates acceptance so that the bypassed read
   // outputs show the reset state while rst is held.
   always_comb begin
      wr_win = '0;
      wr_acc = '0;
      for (int k = 0; k < NUM_WR; k++) begin
         wr_win[k] = we[k] && (wa[k] != '0);
         for (int j = k + 1; j < NUM_WR; j++) begin
            if (we[j] && (wa[j] == wa[k])) begin
               wr_win[k] = 1'b0;
            end
         end
         wr_acc[k] = wr_win[k] && !rst &&
                     (!busy_q[wa[k]] || (tag_q[wa[k]] == wt[k]));
      end
   end

   // Next-state: writes first (judged against the old tag), then issues, so
   // an issue to the same register in the same cycle leaves it busy with the
   // new tag. Loop order gives highest-index priority among issues.
   always_comb begin
      regs_d = regs_q;
      tag_d  = tag_q;
      busy_d = busy_q;
      for (int k = 0; k < NUM_WR; k++) begin
         if (wr_acc[k]) begin
            regs_d[wa[k]] = wd[k];
            busy_d[wa[k]] = 1'b0;
         end
      end
      for (int k = 0; k < NUM_WR; k++) begin
         if (iss_valid[k] && (ia[k] != '0)) begin
            busy_d[ia[k]] = 1'b1;
            tag_d[ia[k]]  = it[k];
         end
      end
      regs_d[0] = '0;
      tag_d[0]  = '0;
      busy_d[0] = 1'b0;
   end

   // Count is taken from the next busy vector so it is exact at the same edge
   always_comb begin
      busy_cnt_d = '0;
      for (int r = 0; r < DEPTH; r++) begin
         busy_cnt_d = busy_cnt_d + {{ADDR_WIDTH{1'b0}}, busy_d[r]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < DEPTH; r++) begin
            regs_q[r] <= '0;
            tag_q[r]  <= '0;
         end
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         regs_q     <= regs_d;
         tag_q      <= tag_d;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign busy_cnt = busy_cnt_q;

   // Read ports. Register 0 is held at zero and never accepts a write, so no
   // explicit address-0 special case is needed here.
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_WIDTH-1:0] rd_addr;
         logic [DATA_WIDTH-1:0] rd_val;
         logic                  rd_busy;
         always_comb begin
            rd_addr = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            rd_val  = regs_q[rd_addr];
            rd_busy = busy_q[rd_addr];
`ifdef RF_SB_BYPASS_EN
            // At most one accepted port can target a given address
            for (int k = 0; k < NUM_WR; k++) begin
               if (wr_acc[k] && (wa[k] == rd_addr)) begin
                  rd_val  = wd[k];
                  rd_busy = 1'b0;
               end
            end
`endif
         end
         assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rd_val;
         assign rbusy[gi]                          = rd_busy;
      end
   endgenerate

   always_comb begin
      dbg_data = regs_q[dbg_addr];
`ifdef RF_SB_BYPASS_EN
      for (int k = 0; k < NUM_WR; k++) begin
         if (wr_acc[k] && (wa[k] == dbg_addr)) begin
            dbg_data = wd[k];
         end
      end
`endif
   end

endmodule

// File: tb/tb_rf_sb_multiport.sv
module tb_rf_sb_multiport;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 4;
   localparam int NW = 2;
   localparam int TW = 4;
   localparam int DEPTH = 32;
`ifdef RF_SB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic [NR*AW-1:0]  raddr;
   logic [NR*DW-1:0]  rdata;
   logic [NR-1:0]     rbusy;
   logic [AW-1:0]     dbg_addr;
   logic [DW-1:0]     dbg_data;
   logic [NW-1:0]     iss_valid;
   logic [NW*AW-1:0]  iss_addr;
   logic [NW*TW-1:0]  iss_tag;
   logic [NW-1:0]     we;
   logic [NW*AW-1:0]  waddr;
   logic [NW*DW-1:0]  wdata;
   logic [NW*TW-1:0]  wtag;
   logic [AW:0]       busy_cnt;

   rf_sb_multiport #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW), .TAG_WIDTH(TW)
   ) dut (
      .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .iss_valid(iss_valid),
      .iss_addr(iss_addr), .iss_tag(iss_tag), .we(we), .waddr(waddr),
      .wdata(wdata), .wtag(wtag), .busy_cnt(busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: architectural contents of the register file
   logic [DW-1:0] m_reg  [DEPTH];
   logic          m_busy [DEPTH];
   logic [TW-1:0] m_tag  [DEPTH];

   int  checks = 0;
   int  errors = 0;
   bit  chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int a = 0; a < DEPTH; a++) begin
         m_reg[a]  = '0;
         m_busy[a] = 1'b0;
         m_tag[a]  = '0;
      end
   endtask

   // Is there an accepted writeback to register a this cycle, and with what data?
   // The highest-index port naming a is the only candidate; it is accepted when
   // the register is idle or waiting on exactly that tag.
   function automatic bit accept(input logic [AW-1:0] a, output logic [DW-1:0] d);
      d = '0;
      if (a == '0) return 1'b0;
      for (int k = NW - 1; k >= 0; k--) begin
         if (we[k] && waddr[k*AW +: AW] == a) begin
            if (!m_busy[a] || m_tag[a] == wtag[k*TW +: TW]) begin
               d = wdata[k*DW +: DW];
               return 1'b1;
            end
            return 1'b0;
         end
      end
      return 1'b0;
   endfunction

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      logic [DW-1:0] d;
      if (rst || a == '0) return '0;
      if (BYP && accept(a, d)) return d;
      return m_reg[a];
   endfunction

   function automatic logic exp_rb(input logic [AW-1:0] a);
      logic [DW-1:0] d;
      if (rst || a == '0) return 1'b0;
      if (BYP && accept(a, d)) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic int exp_cnt();
      int n = 0;
      for (int a = 0; a < DEPTH; a++) if (m_busy[a]) n++;
      return n;
   endfunction

   task automatic model_update();
      logic [DW-1:0] nreg  [DEPTH];
      logic          nbusy [DEPTH];
      logic [TW-1:0] ntag  [DEPTH];
      logic [DW-1:0] d;
      for (int a = 0; a < DEPTH; a++) begin
         nreg[a] = m_reg[a]; nbusy[a] = m_busy[a]; ntag[a] = m_tag[a];
      end
      for (int a = 1; a < DEPTH; a++) begin
         if (accept(AW'(a), d)) begin
            nreg[a]  = d;
            nbusy[a] = 1'b0;
         end
         for (int k = NW - 1; k >= 0; k--) begin
            if (iss_valid[k] && iss_addr[k*AW +: AW] == AW'(a)) begin
               nbusy[a] = 1'b1;
               ntag[a]  = iss_tag[k*TW +: TW];
               break;
            end
         end
      end
      for (int a = 0; a < DEPTH; a++) begin
         m_reg[a] = nreg[a]; m_busy[a] = nbusy[a]; m_tag[a] = ntag[a];
      end
   endtask

   // Single compare process: every negedge, all outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < NR; i++) begin
            chk($sformatf("rdata%0d", i), 64'(rdata[i*DW +: DW]), 64'(exp_rd(raddr[i*AW +: AW])));
            chk($sformatf("rbusy%0d", i), 64'(rbusy[i]), 64'(exp_rb(raddr[i*AW +: AW])));
         end
         chk("dbg_data", 64'(dbg_data), 64'(exp_rd(dbg_addr)));
         chk("busy_cnt", 64'(busy_cnt), 64'(exp_cnt()));
      end
   end

   task automatic quiet();
      we = '0; waddr = '0; wdata = '0; wtag = '0;
      iss_valid = '0; iss_addr = '0; iss_tag = '0;
      raddr = '0; dbg_addr = '0;
   endtask

   task automatic wr(input int k, input int a, input logic [DW-1:0] d, input int t);
      we[k] = 1'b1;
      waddr[k*AW +: AW] = AW'(a);
      wdata[k*DW +: DW] = d;
      wtag[k*TW +: TW]  = TW'(t);
   endtask

   task automatic iss(input int k, input int a, input int t);
      iss_valid[k] = 1'b1;
      iss_addr[k*AW +: AW] = AW'(a);
      iss_tag[k*TW +: TW]  = TW'(t);
   endtask

   task automatic rd(input int i, input int a);
      raddr[i*AW +: AW] = AW'(a);
   endtask

   // Advance one clock; the model commits at the same edge as the DUT
   task automatic step();
      @(posedge clk);
      if (!rst) model_update();
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic [AW-1:0] a;
      rst = 1'b1;
      quiet();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy_cnt", 64'(busy_cnt), 64'd0);
      chk("reset_rdata", 64'(rdata), 64'd0);
      rst = 1'b0;
      chk_en = 1'b1;

      // Write r5, issue r5 busy, then asynchronous reset in mid-cycle
      quiet(); wr(0, 5, 32'h1234, 0); step();
      quiet(); iss(0, 5, 1); rd(0, 5); #2;
      chk("r5_data", 64'(rdata[0 +: DW]), 64'h1234);
      chk("r5_busy_not_yet", 64'(rbusy[0]), 64'd0);
      step();
      quiet(); rd(0, 5); #2;
      chk("r5_busy", 64'(rbusy[0]), 64'd1);
      chk("r5_cnt", 64'(busy_cnt), 64'd1);
      rst = 1'b1; model_reset(); #1;
      chk("mid_rst_data", 64'(rdata[0 +: DW]), 64'd0);
      chk("mid_rst_busy", 64'(rbusy[0]), 64'd0);
      chk("mid_rst_cnt", 64'(busy_cnt), 64'd0);
      @(posedge clk); #1; rst = 1'b0;

      // Issue r3 tag 2, then matching writeback
      quiet(); iss(0, 3, 2); step();
      quiet(); wr(0, 3, 32'hAA, 2); rd(0, 3); #2;
      chk("r3_wb_data", 64'(rdata[0 +: DW]), BYP ? 64'hAA : 64'h0);
      chk("r3_wb_busy", 64'(rbusy[0]), BYP ? 64'd0 : 64'd1);
      step();
      quiet(); rd(0, 3); #2;
      chk("r3_after_data", 64'(rdata[0 +: DW]), 64'hAA);
      chk("r3_after_cnt", 64'(busy_cnt), 64'd0);

      // Retag r3: stale writeback is dropped, current one lands
      quiet(); iss(0, 3, 2); step();
      quiet(); iss(1, 3, 7); step();
      quiet(); wr(0, 3, 32'h11, 2); step();
      quiet(); rd(0, 3); #2;
      chk("stale_data", 64'(rdata[0 +: DW]), 64'hAA);
      chk("stale_busy", 64'(rbusy[0]), 64'd1);
      chk("stale_cnt", 64'(busy_cnt), 64'd1);
      quiet(); wr(1, 3, 32'h22, 7); step();
      quiet(); rd(0, 3); #2;
      chk("retag_data", 64'(rdata[0 +: DW]), 64'h22);
      chk("retag_busy", 64'(rbusy[0]), 64'd0);
      chk("retag_cnt", 64'(busy_cnt), 64'd0);

      // Both write ports on r9: higher port wins
      quiet(); wr(0, 9, 32'h1, 0); wr(1, 9, 32'h2, 0); rd(1, 9); #2;
      chk("r9_same", 64'(rdata[DW +: DW]), BYP ? 64'h2 : 64'h0);
      step();
      quiet(); rd(1, 9); #2;
      chk("r9_next", 64'(rdata[DW +: DW]), 64'h2);

      // r0 ignores writes and issues
      quiet(); wr(0, 0, 32'hFFFF, 0); iss(1, 0, 5); rd(2, 0); #2;
      chk("r0_data", 64'(rdata[2*DW +: DW]), 64'd0);
      chk("r0_busy", 64'(rbusy[2]), 64'd0);
      step();
      quiet(); rd(2, 0); #2;
      chk("r0_data_next", 64'(rdata[2*DW +: DW]), 64'd0);
      chk("r0_cnt", 64'(busy_cnt), 64'd0);

      // r4 overwrite: old value same cycle without bypass
      quiet(); wr(0, 4, 32'h10, 0); step();
      quiet(); wr(1, 4, 32'h55, 0); rd(3, 4); dbg_addr = 5'd4; #2;
      chk("r4_same", 64'(rdata[3*DW +: DW]), BYP ? 64'h55 : 64'h10);
      chk("r4_dbg_same", 64'(dbg_data), BYP ? 64'h55 : 64'h10);
      step();
      quiet(); rd(3, 4); dbg_addr = 5'd4; #2;
      chk("r4_next", 64'(rdata[3*DW +: DW]), 64'h55);
      chk("r4_dbg_next", 64'(dbg_data), 64'h55);

      // Randomized traffic over a small address window to force collisions
      for (int n = 0; n < 400; n++) begin
         quiet();
         for (int k = 0; k < NW; k++) begin
            we[k] = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 7));
            waddr[k*AW +: AW] = a;
            wdata[k*DW +: DW] = $urandom;
            wtag[k*TW +: TW]  = ($urandom_range(0, 1) == 1) ? m_tag[a] : TW'($urandom_range(0, 3));
            iss_valid[k] = ($urandom_range(0, 2) == 0);
            iss_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
            iss_tag[k*TW +: TW]  = TW'($urandom_range(0, 3));
         end
         for (int i = 0; i < NR; i++) rd(i, $urandom_range(0, 7));
         dbg_addr = AW'($urandom_range(0, 7));
         if (n == 200) begin
            #2;
            rst = 1'b1; model_reset(); #1;
            chk("rand_rst_cnt", 64'(busy_cnt), 64'd0);
            chk("rand_rst_dbg", 64'(dbg_data), 64'd0);
            @(posedge clk); #1; rst = 1'b0;
         end else begin
            step();
         end
      end

      quiet();
      step();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
